// File: rtl/div_32_16_seq_pkg.sv
// Shared definitions for the 32/16 sequential signed divider.
// Covers the FSM state encoding, the default operand width and the iteration counter width.
package div_32_16_seq_pkg;

    localparam int DEF_DW    = 16;
    localparam int DEF_CNT_W = $clog2(2 * DEF_DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_32_16_seq_udiv_step.sv
// One restoring division step on magnitudes.
// Shifts the next dividend bit into the partial remainder, then trial-subtracts the divisor.
module udiv_step #(
    parameter int DW = 16
) (
    input  logic [DW:0] rem,
    input  logic        din,
    input  logic [DW:0] dvs,
    output logic [DW:0] rem_next,
    output logic        qbit
);

    logic [DW+1:0] shifted;
    logic [DW+1:0] diff;

    // The remainder is always below the divisor (at most 2^DW), so the shifted value
    // fits in DW+1 bits. The extra top bit of diff then acts as the borrow flag.
    assign shifted  = {rem, din};
    assign diff     = shifted - {1'b0, dvs};
    assign qbit     = ~diff[DW+1];
    assign rem_next = qbit ? diff[DW:0] : shifted[DW:0];

endmodule

// File: rtl/div_32_16_seq.sv
// Sequential signed divider: a 2*DW-bit dividend divided by a DW-bit divisor.
// Produces a quotient truncated toward zero, plus a remainder and overflow/divide-by-zero flags.
module div_32_16_seq
    import div_32_16_seq_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] DIVIDEND,
    input  logic [DW-1:0]   DIVISOR,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   QUOT,
    output logic [DW-1:0]   REM,
    output logic            ovf,
    output logic            div_zero
);

    localparam int CW = $clog2(2 * DW);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [DW:0]     rem_reg;
    logic [DW:0]     dvs_reg;
    logic [2*DW-1:0] dvd_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic [DW-1:0]   quot_reg;
    logic [DW-1:0]   rem_out_reg;
    logic            ovf_reg;
    logic            dz_reg;

    logic            accept;
    logic            dvs_is_zero;
    logic            calc_last;
    logic [2*DW-1:0] dvd_mag;
    logic [DW:0]     dvs_ext;
    logic [DW:0]     dvs_mag;
    logic [DW:0]     step_rem;
    logic            step_q;
    logic [2*DW:0]   q_ext;
    logic [2*DW:0]   q_signed;
    logic [DW:0]     q_top;
    logic            q_ovf;
    logic [DW-1:0]   r_signed;

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign accept      = in_valid & in_ready;
    assign dvs_is_zero = (DIVISOR == '0);
    assign calc_last   = (cnt_reg == CW'(2 * DW - 1));

    // The unsigned magnitude of the most negative dividend still fits in 2*DW bits.
    // The divisor is sign-extended by one bit, so 0x8000 keeps its full magnitude.
    assign dvd_mag = DIVIDEND[2*DW-1] ? -DIVIDEND : DIVIDEND;
    assign dvs_ext = {DIVISOR[DW-1], DIVISOR};
    assign dvs_mag = dvs_ext[DW] ? -dvs_ext : dvs_ext;

    udiv_step #(.DW(DW)) u_step (
        .rem      (rem_reg),
        .din      (dvd_reg[2*DW-1]),
        .dvs      (dvs_reg),
        .rem_next (step_rem),
        .qbit     (step_q)
    );

    // A quotient magnitude of 2^(2*DW-1) with a positive sign needs one extra bit.
    assign q_ext    = {1'b0, dvd_reg};
    assign q_signed = neg_q_reg ? -q_ext : q_ext;
    assign q_top    = q_signed[2*DW:DW-1];
    assign q_ovf    = ~((&q_top) | ~(|q_top));
    assign r_signed = neg_r_reg ? -rem_reg[DW-1:0] : rem_reg[DW-1:0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = dvs_is_zero ? DONE : CALC;
            CALC: if (calc_last) state_next = SIGN;
            SIGN: state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_reg     <= '0;
            rem_reg     <= '0;
            dvs_reg     <= '0;
            dvd_reg     <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            quot_reg    <= '0;
            rem_out_reg <= '0;
            ovf_reg     <= 1'b0;
            dz_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        neg_q_reg <= DIVIDEND[2*DW-1] ^ DIVISOR[DW-1];
                        neg_r_reg <= DIVIDEND[2*DW-1];
                        dvd_reg   <= dvd_mag;
                        dvs_reg   <= dvs_mag;
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        if (dvs_is_zero) begin
                            quot_reg    <= '0;
                            rem_out_reg <= '0;
                            ovf_reg     <= 1'b0;
                            dz_reg      <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    // dvd_reg shifts dividend bits out and quotient bits in.
                    rem_reg <= step_rem;
                    dvd_reg <= {dvd_reg[2*DW-2:0], step_q};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                SIGN: begin
                    quot_reg    <= q_signed[DW-1:0];
                    rem_out_reg <= r_signed;
                    ovf_reg     <= q_ovf;
                    dz_reg      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign QUOT     = quot_reg;
    assign REM      = rem_out_reg;
    assign ovf      = ovf_reg;
    assign div_zero = dz_reg;

endmodule

// File: tb/tb_div_32_16_seq.sv
// Testbench for div_32_16_seq: table vectors, handshake/backpressure, reset abort, random pairs.
// Expected results are queued at accept and checked when the result is taken.
module tb_div_32_16_seq;

    localparam int DW = 16;

    logic            sys_clk   = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic [2*DW-1:0] DIVIDEND  = '0;
    logic [DW-1:0]   DIVISOR   = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   QUOT;
    logic [DW-1:0]   REM;
    logic            ovf;
    logic            div_zero;

    always #5 sys_clk = ~sys_clk;

    div_32_16_seq #(.DW(DW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .DIVIDEND  (DIVIDEND),
        .DIVISOR   (DIVISOR),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .QUOT      (QUOT),
        .REM       (REM),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        ovf;
        logic        dz;
    } vec_t;

    vec_t exp_q[$];
    vec_t table_v[12];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic [31:0] a, input logic [15:0] b,
                                input logic [15:0] q, input logic [15:0] r,
                                input logic o, input logic z);
        vec_t v;
        v.dvd = a; v.dvs = b; v.q = q; v.r = r; v.ovf = o; v.dz = z;
        return v;
    endfunction

    // Reference model built on the simulator's own signed division (truncation toward zero).
    function automatic vec_t model(input logic [31:0] a, input logic [15:0] b);
        vec_t   v;
        longint sa, sb, q, r;
        v.dvd = a;
        v.dvs = b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            v.q = '0; v.r = '0; v.ovf = 1'b0; v.dz = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            v.q   = q[15:0];
            v.r   = r[15:0];
            v.ovf = (q > 32767) || (q < -32768);
            v.dz  = 1'b0;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic compare_out(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        $display("[TB] %s dvd=%h dvs=%h -> quot=%h rem=%h ovf=%b dz=%b",
                 tag, e.dvd, e.dvs, QUOT, REM, ovf, div_zero);
        check({tag, " QUOT"},     64'(QUOT),     64'(e.q));
        check({tag, " REM"},      64'(REM),      64'(e.r));
        check({tag, " ovf"},      64'(ovf),      64'(e.ovf));
        check({tag, " div_zero"}, 64'(div_zero), 64'(e.dz));
        if (!e.ovf && !e.dz)
            check({tag, " identity"},
                  64'(longint'($signed(QUOT)) * longint'($signed(e.dvs)) + longint'($signed(REM))),
                  64'(longint'($signed(e.dvd))));
    endtask

    // Issue one operation with out_ready high. Latency is counted from the accept edge, inclusive.
    task automatic run_op(input string tag, input vec_t e);
        int lat;
        int guard;
        @(negedge sys_clk);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge sys_clk);
            guard++;
        end
        if (!in_ready) begin
            check({tag, " in_ready timeout"}, 64'd0, 64'd1);
            return;
        end
        in_valid = 1'b1;
        DIVIDEND = e.dvd;
        DIVISOR  = e.dvs;
        @(posedge sys_clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        DIVIDEND = $urandom;
        DIVISOR  = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge sys_clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), e.dz ? 64'd1 : 64'd34);
        if (!out_valid) begin
            exp_q.delete();
            return;
        end
        @(negedge sys_clk);
        compare_out(tag);
        @(posedge sys_clk);
        #1;
        check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        e;
        logic [31:0] a;
        logic [15:0] b;
        logic [15:0] x;
        int          guard;

        table_v[0]  = mk(32'h139DFF24, 16'h5E81, 16'h3524, 16'h0000, 1'b0, 1'b0);
        table_v[1]  = mk(32'hFFFFFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
        table_v[2]  = mk(32'h00000007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
        table_v[3]  = mk(32'hFFFFFFF9, 16'hFFFE, 16'h0003, 16'hFFFF, 1'b0, 1'b0);
        table_v[4]  = mk(32'h00010000, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0);
        table_v[5]  = mk(32'h80000000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0);
        table_v[6]  = mk(32'h00001234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        table_v[7]  = mk(32'h80000000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        table_v[8]  = mk(32'hC0000000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0);
        table_v[9]  = mk(32'h40000000, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0);
        table_v[10] = mk(32'h00000064, 16'h8000, 16'h0000, 16'h0064, 1'b0, 1'b0);
        table_v[11] = mk(32'h7FFFFFFF, 16'h7FFF, 16'h0002, 16'h0001, 1'b1, 1'b0);

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset in_ready",  64'(in_ready),  64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset QUOT",      64'(QUOT),      64'd0);
        check("reset REM",       64'(REM),       64'd0);
        check("reset ovf",       64'(ovf),       64'd0);
        check("reset div_zero",  64'(div_zero),  64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), table_v[i]);
        end

        // Backpressure: hold the result in DONE while new operands are offered.
        out_ready = 1'b0;
        e = model(32'd100, 16'd7);
        @(negedge sys_clk);
        in_valid = 1'b1; DIVIDEND = 32'd100; DIVISOR = 16'd7;
        @(posedge sys_clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge sys_clk);
            #1;
            guard++;
        end
        check("bp result timeout", 64'(out_valid), 64'd1);
        @(negedge sys_clk);
        in_valid = 1'b1; DIVIDEND = 32'd55; DIVISOR = 16'd5;
        for (int k = 0; k < 10; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            check("bp hold QUOT",      64'(QUOT),      64'(e.q));
            check("bp hold REM",       64'(REM),       64'(e.r));
            check("bp hold in_ready",  64'(in_ready),  64'd0);
            check("bp hold out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        compare_out("bp");
        @(posedge sys_clk);
        #1;
        check("bp release out_valid", 64'(out_valid), 64'd0);
        check("bp release in_ready",  64'(in_ready),  64'd1);
        check("bp release QUOT kept", 64'(QUOT),      64'(e.q));
        in_valid = 1'b0;

        // Reset during CALC aborts the operation; the next one completes normally.
        e = model(32'h139DFF24, 16'h5E81);
        @(negedge sys_clk);
        in_valid = 1'b1; DIVIDEND = e.dvd; DIVISOR = e.dvs;
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge sys_clk);
        #1;
        check("abort busy in_ready", 64'(in_ready), 64'd0);
        sys_rst_n = 1'b0;
        #1;
        check("abort in_ready",  64'(in_ready),  64'd1);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort QUOT",      64'(QUOT),      64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run_op("post-abort", e);

        // Random pairs, half of them built as product plus small offset so ovf is mostly clear.
        for (int i = 0; i < 300; i++) begin
            do b = 16'($urandom); while (b == 16'h0000);
            if (i % 2 == 0) begin
                a = $urandom;
            end else begin
                x = 16'($urandom);
                a = 32'(longint'($signed(x)) * longint'($signed(b))) + 32'($urandom_range(0, 3));
            end
            run_op($sformatf("rand%0d", i), model(a, b));
        end

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
